// File: rtl/operand_input_port.sv
// operand_input_port
//   Operand entry front-end for the CPU lab board. The raw active-low button
//   and the switch bank are synchronized. The button is then debounced. Each
//   accepted press captures the synchronized switch value and offers it to the
//   CPU with a valid/ack handshake. A 2-bit operand index (X/Y/Z/Answer)
//   follows the accepted presses for the state digit on the display.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before the debounced level moves (>= 2)
//   DATA_W           switch / data width
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   btn_n        raw pushbutton, active-low, asynchronous, bouncy
//   sw           raw switches, asynchronous
//   rd_ack       CPU has consumed data_out
//   data_out     captured operand
//   data_valid   data_out holds an unconsumed operand
//   overrun      sticky: a press was rejected while data was unconsumed
//   operand_idx  accepted operands mod 4 (0=X, 1=Y, 2=Z, 3=Answer)
module operand_input_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned DATA_W          = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_n,
   input  logic [DATA_W-1:0] sw,
   input  logic              rd_ack,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              overrun,
   output logic [1:0]        operand_idx
);

   localparam int unsigned      CntW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0]  CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   localparam logic [0:0] StEmpty = 1'b0;
   localparam logic [0:0] StFull  = 1'b1;

   // Two-flop synchronizers
   logic              btn_meta_q, btn_s_q;
   logic [DATA_W-1:0] sw_meta_q, sw_s_q;

   // Debounce
   logic              btn_db_q, btn_db_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              press_evt;

   // Handshake
   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovr_q, ovr_d;
   logic [1:0]        idx_q, idx_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta_q <= 1'b1;
         btn_s_q    <= 1'b1;
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
      end else begin
         btn_meta_q <= btn_n;
         btn_s_q    <= btn_meta_q;
         sw_meta_q  <= sw;
         sw_s_q     <= sw_meta_q;
      end
   end

   // cnt counts consecutive cycles on which btn_s disagrees with btn_db. Any
   // agreement restarts the count, so short glitches never move btn_db.
   always_comb begin
      btn_db_d = btn_db_q;
      cnt_d    = '0;
      if (btn_s_q != btn_db_q) begin
         if (cnt_q == CntMax) begin
            btn_db_d = btn_s_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   // A press is the edge on which the debounced level falls. Capture happens
   // on that same edge.
   assign press_evt = btn_db_q & ~btn_db_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      idx_d   = idx_q;
      case (state_q)
         StEmpty: begin
            if (press_evt) begin
               data_d  = sw_s_q;
               idx_d   = idx_q + 2'd1;
               state_d = StFull;
            end
         end
         StFull: begin
            if (press_evt && rd_ack) begin
               // Old value is consumed and the new one is captured together.
               data_d = sw_s_q;
               idx_d  = idx_q + 2'd1;
            end else if (press_evt) begin
               ovr_d = 1'b1;
            end else if (rd_ack) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_db_q <= 1'b1;
         cnt_q    <= '0;
         state_q  <= StEmpty;
         data_q   <= '0;
         ovr_q    <= 1'b0;
         idx_q    <= 2'd0;
      end else begin
         btn_db_q <= btn_db_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         data_q   <= data_d;
         ovr_q    <= ovr_d;
         idx_q    <= idx_d;
      end
   end

   assign data_out    = data_q;
   assign data_valid  = (state_q == StFull);
   assign overrun     = ovr_q;
   assign operand_idx = idx_q;

endmodule

// File: tb/tb_operand_input_port.sv
// Bench for operand_input_port: directed table, hand-written corner sequences
// and random stimulus, all compared against a cycle-level reference model.
module tb_operand_input_port;

   localparam int unsigned D = 4;

   logic       clk;
   logic       reset;
   logic       btn_n;
   logic [7:0] sw;
   logic       rd_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       overrun;
   logic [1:0] operand_idx;

   int n_checks = 0;
   int n_errors = 0;

   operand_input_port #(
      .DEBOUNCE_CYCLES(D),
      .DATA_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n),
      .sw(sw),
      .rd_ack(rd_ack),
      .data_out(data_out),
      .data_valid(data_valid),
      .overrun(overrun),
      .operand_idx(operand_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. Raw inputs reach the logic two edges late. The debounced
   // level flips once the last D synchronized samples all disagree with it.
   logic       m_btn_hist[2];
   logic [7:0] m_sw_hist[2];
   logic       m_win[$];
   logic       m_db;
   logic       m_valid;
   logic [7:0] m_data;
   int         m_count;
   logic       m_ovr;

   function automatic void model_reset();
      m_btn_hist[0] = 1'b1;
      m_btn_hist[1] = 1'b1;
      m_sw_hist[0]  = 8'h00;
      m_sw_hist[1]  = 8'h00;
      m_win.delete();
      for (int i = 0; i < D; i++) m_win.push_back(1'b1);
      m_db    = 1'b1;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_count = 0;
      m_ovr   = 1'b0;
   endfunction

   function automatic void model_step(input logic b, input logic [7:0] s, input logic a);
      logic       bs;
      logic [7:0] ss;
      logic       press;
      bit         all_diff;
      bs = m_btn_hist[0];
      ss = m_sw_hist[0];
      m_btn_hist[0] = m_btn_hist[1];
      m_btn_hist[1] = b;
      m_sw_hist[0]  = m_sw_hist[1];
      m_sw_hist[1]  = s;
      m_win.push_back(bs);
      while (m_win.size() > D) void'(m_win.pop_front());
      all_diff = 1'b1;
      foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 1'b0;
      press = 1'b0;
      if (all_diff) begin
         m_db  = ~m_db;
         press = (m_db == 1'b0);
      end
      if (press) begin
         if (!m_valid || a) begin
            m_data  = ss;
            m_valid = 1'b1;
            m_count = m_count + 1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (a) begin
         m_valid = 1'b0;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
      chk({tag, ".data"},  32'(data_out),   32'(m_data));
      chk({tag, ".idx"},   32'(operand_idx), 32'(m_count % 4));
      chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(data_valid), 32'd0);
      chk({tag, ".data"},  32'(data_out),   32'd0);
      chk({tag, ".idx"},   32'(operand_idx), 32'd0);
      chk({tag, ".ovr"},   32'(overrun),    32'd0);
   endtask

   // One clock edge with the given inputs, then compare against the model.
   task automatic tick(input logic b, input logic [7:0] s, input logic a);
      btn_n  = b;
      sw     = s;
      rd_ack = a;
      @(posedge clk);
      model_step(b, s, a);
      #1;
      chk_model("model");
   endtask

   task automatic do_reset(input int n, input logic b, input logic [7:0] s);
      reset  = 1'b0;
      btn_n  = b;
      sw     = s;
      rd_ack = 1'b0;
      #1;
      model_reset();
      chk_zero("rst_assert");
      repeat (n) @(posedge clk);
      #1;
      chk_zero("rst_hold");
      reset = 1'b1;
   endtask

   typedef struct {
      logic       btn;
      logic [7:0] sw;
      logic       ack;
      int         reps;
      logic       v;
      logic [7:0] d;
      logic [1:0] i;
      logic       o;
   } vec_t;

   vec_t tbl[6];

   logic       r_btn;
   logic [7:0] r_sw;

   initial begin
      // Clean press and single ack, expectations written out by hand.
      tbl[0] = '{1'b0, 8'h5A, 1'b0, 5,  1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1] = '{1'b0, 8'h5A, 1'b0, 1,  1'b1, 8'h5A, 2'd1, 1'b0};
      tbl[2] = '{1'b0, 8'h5A, 1'b0, 14, 1'b1, 8'h5A, 2'd1, 1'b0};
      tbl[3] = '{1'b1, 8'h5A, 1'b0, 10, 1'b1, 8'h5A, 2'd1, 1'b0};
      tbl[4] = '{1'b1, 8'h5A, 1'b1, 1,  1'b0, 8'h5A, 2'd1, 1'b0};
      tbl[5] = '{1'b1, 8'h5A, 1'b0, 3,  1'b0, 8'h5A, 2'd1, 1'b0};

      reset  = 1'b1;
      btn_n  = 1'b1;
      sw     = 8'hFF;
      rd_ack = 1'b0;
      model_reset();

      // Reset with switches all high
      do_reset(3, 1'b1, 8'hFF);
      tick(1'b1, 8'hFF, 1'b0);
      chk_zero("rst_after");
      repeat (4) tick(1'b1, 8'h5A, 1'b0);

      // Clean press from the table
      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].reps; r++) begin
            tick(tbl[k].btn, tbl[k].sw, tbl[k].ack);
            chk("tbl.valid", 32'(data_valid), 32'(tbl[k].v));
            chk("tbl.data",  32'(data_out),   32'(tbl[k].d));
            chk("tbl.idx",   32'(operand_idx), 32'(tbl[k].i));
            chk("tbl.ovr",   32'(overrun),    32'(tbl[k].o));
         end
      end

      // Bounce: low 2, high 1, low 3, high 2, then high
      do_reset(2, 1'b1, 8'h33);
      repeat (2) tick(1'b0, 8'h33, 1'b0);
      tick(1'b1, 8'h33, 1'b0);
      repeat (3) tick(1'b0, 8'h33, 1'b0);
      repeat (12) tick(1'b1, 8'h33, 1'b0);
      chk("bounce.valid", 32'(data_valid), 32'd0);
      chk("bounce.idx",   32'(operand_idx), 32'd0);

      // Overrun
      do_reset(2, 1'b1, 8'h11);
      repeat (3) tick(1'b1, 8'h11, 1'b0);
      repeat (8) tick(1'b0, 8'h11, 1'b0);
      repeat (8) tick(1'b1, 8'h22, 1'b0);
      repeat (8) tick(1'b0, 8'h22, 1'b0);
      chk("ovr.data",  32'(data_out),   32'h11);
      chk("ovr.idx",   32'(operand_idx), 32'd1);
      chk("ovr.flag",  32'(overrun),    32'd1);
      chk("ovr.valid", 32'(data_valid), 32'd1);
      tick(1'b0, 8'h22, 1'b1);
      tick(1'b0, 8'h22, 1'b0);
      chk("ovr.ack_valid", 32'(data_valid), 32'd0);
      chk("ovr.sticky",    32'(overrun),    32'd1);

      // Ack on the exact capture edge of a second press
      do_reset(2, 1'b1, 8'h11);
      repeat (3) tick(1'b1, 8'h11, 1'b0);
      repeat (8) tick(1'b0, 8'h11, 1'b0);
      repeat (8) tick(1'b1, 8'h22, 1'b0);
      repeat (5) tick(1'b0, 8'h22, 1'b0);
      chk("sim.pre_data", 32'(data_out), 32'h11);
      tick(1'b0, 8'h22, 1'b1);
      chk("sim.data",  32'(data_out),   32'h22);
      chk("sim.valid", 32'(data_valid), 32'd1);
      chk("sim.idx",   32'(operand_idx), 32'd2);
      chk("sim.ovr",   32'(overrun),    32'd0);

      // Wrap through four acked presses
      do_reset(2, 1'b1, 8'h00);
      for (int p = 1; p <= 4; p++) begin
         repeat (3) tick(1'b1, 8'(8'hA0 + p), 1'b0);
         repeat (8) tick(1'b0, 8'(8'hA0 + p), 1'b0);
         chk("wrap.idx",  32'(operand_idx), 32'(p % 4));
         chk("wrap.data", 32'(data_out),   32'(8'hA0 + p));
         tick(1'b0, 8'(8'hA0 + p), 1'b1);
         repeat (8) tick(1'b1, 8'(8'hA0 + p), 1'b0);
      end

      // Reset at debounce edge 4, button released while reset is held
      repeat (4) tick(1'b0, 8'h77, 1'b0);
      do_reset(3, 1'b1, 8'h77);
      repeat (12) tick(1'b1, 8'h77, 1'b0);
      chk("midrst.valid", 32'(data_valid), 32'd0);
      chk("midrst.idx",   32'(operand_idx), 32'd0);

      // Button held low through reset release counts as one press
      do_reset(2, 1'b0, 8'h3C);
      repeat (5) tick(1'b0, 8'h3C, 1'b0);
      chk("held.early", 32'(data_valid), 32'd0);
      tick(1'b0, 8'h3C, 1'b0);
      chk("held.valid", 32'(data_valid), 32'd1);
      chk("held.data",  32'(data_out),   32'h3C);
      repeat (10) tick(1'b0, 8'h3C, 1'b1);
      chk("held.idx",   32'(operand_idx), 32'd1);

      // Random bouncy presses, switch changes and acks
      do_reset(2, 1'b1, 8'h00);
      r_btn = 1'b1;
      r_sw  = 8'h00;
      for (int seg = 0; seg < 300; seg++) begin
         int len;
         r_btn = ~r_btn;
         len   = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 5) == 0) r_sw = 8'($urandom);
            tick(r_btn, r_sw, ($urandom_range(0, 7) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_input_port.md
# operand_input_port

Operand entry front-end for the simple CPU lab board: it turns the raw active-low pushbutton and the 8 slide switches into a clean, one-value-at-a-time handshake toward the CPU's input read port. It synchronizes and debounces the button and captures the synchronized switch value on each accepted press. It holds that value valid until the CPU acknowledges the read. It also tracks which operand (X/Y/Z/Answer) is next, for the state digit on the seven-segment display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before the debounced button level changes; legal range ≥2.
- DATA_W, default 8: switch/data width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_n  input  1  raw pushbutton, active-low, asynchronous to clk, may bounce.
- sw  input  DATA_W  raw switches, asynchronous to clk.
- rd_ack  input  1  CPU has consumed data_out; sampled on the clock edge.
- data_out  output  DATA_W  captured operand.
- data_valid  output  1  data_out holds an unconsumed operand.
- overrun  output  1  sticky: a press was rejected because data was still unconsumed.
- operand_idx  output  2  count of accepted operands mod 4: 0=X, 1=Y, 2=Z, 3=Answer.

## Operation
- Synchronization: btn_n and sw each pass through 2 flops: btn_s and sw_s.
- Debounce: level register btn_db plus counter cnt.
  - btn_s == btn_db: cnt clears to 0.
  - btn_s != btn_db and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - btn_s != btn_db and cnt == DEBOUNCE_CYCLES-1: btn_db takes btn_s and cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press event: the edge on which btn_db goes 1→0. Release (0→1) generates no event. A held button yields exactly one event.
- Handshake state machine:
  - EMPTY (data_valid=0):
    - Press event: data_out←sw_s, data_valid←1, operand_idx increments, go to FULL.
    - rd_ack is ignored.
  - FULL (data_valid=1):
    - rd_ack alone: data_valid←0, go to EMPTY. data_out holds its last value.
    - Press event alone: rejected. data_out and operand_idx unchanged, overrun←1.
    - rd_ack and press event on the same edge: the old value is consumed and the new one captured. data_out←sw_s, data_valid stays 1, operand_idx increments, overrun unchanged.
- operand_idx wraps 3→0.
- overrun clears only on reset.
- Reset values:
  - data_out=0, data_valid=0, overrun=0, operand_idx=0.
  - btn sync flops and btn_db=1 (released); sw sync flops=0; cnt=0.
- Reset asserted mid-debounce or mid-handshake: everything returns to the reset values immediately; a pending operand is discarded.
- A button held low through reset release is accepted as one press once it has passed sync plus debounce.

## Timing
- Number edges from edge 1, the first rising edge that samples btn_n low; btn_n stays low from then on.
  - btn_s low after edge 2.
  - btn_db falls, data is captured and data_valid rises at edge DEBOUNCE_CYCLES+2 (edge 6 at the default).
- The captured value is sw_s at that edge, i.e. sw as sampled 2 edges earlier. sw must be stable for ≥3 cycles before the capture edge.
- rd_ack high at edge N with data_valid=1: data_valid low after edge N.
- rd_ack may be a single-cycle pulse; holding it high while EMPTY has no effect.
- Release latency matches press latency, but release has no visible effect on the outputs.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset: assert reset low for 3 cycles with btn_n=1 and sw=0xFF -> data_out=0x00, data_valid=0, overrun=0, operand_idx=0, both during reset and after release.
- Clean press: sw=0x5A, btn_n low for 20 cycles then high, DEBOUNCE_CYCLES=4 -> data_valid rises at edge 6, data_out=0x5A, operand_idx=1, a single capture only. A 1-cycle rd_ack then gives data_valid=0 and data_out still 0x5A.
- Bounce: btn_n low 2, high 1, low 3, high 2 cycles, then high -> no capture, data_valid stays 0, operand_idx stays 0.
- Overrun: press with sw=0x11 (no ack), release, then press with sw=0x22 -> data_out=0x11, operand_idx=1, overrun=1. After rd_ack, overrun stays 1.
- Simultaneous: FULL with 0x11, sw=0x22, rd_ack pulsed on the exact capture edge -> data_out=0x22, data_valid stays 1, operand_idx increments, overrun unchanged.
- Wrap and reset mid-operation:
  - 4 accepted presses, each acked -> operand_idx sequence 1, 2, 3, 0.
  - Then press and assert reset at edge 4 of the debounce -> all outputs 0.
  - Release btn_n before reset deasserts -> no capture afterwards.
